sobel_window: RTL and testbench

- Upstream neighbour of the Sobel kernel stage.
- Accepts a raster-order pixel stream and buffers two image lines in on-chip line memories.
- Emits a registered 3x3 pixel neighbourhood plus centre coordinates for every interior pixel.
- The kernel consumes one window per win_valid_o pulse; no backpressure exists in this path.

---
 rtl/sobel_window.sv | 145 ++++++++++++++
 tb/tb_sobel_window.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sobel_window.sv
// sobel_window
//   Turns a raster-order pixel stream into registered 3x3 neighbourhoods for
//   the Sobel kernel stage. Two line memories hold the previous two image
//   rows; a 3x3 register array shifts one column per accepted pixel.
//
// Handshake: pix_valid_i qualifies pix_i and sof_i in the same cycle. There
//   is no ready; every valid pixel is consumed on the clock edge it is
//   presented. win_valid_o qualifies win_o/win_x_o/win_y_o/eof_o for exactly
//   one cycle and the downstream kernel must take it then.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   pix_i        input pixel
//   pix_valid_i  pix_i valid this cycle
//   sof_i        with pix_valid_i, pixel is (0,0) of a new frame
//   win_o        3x3 window, element (r,c) at [(r*3+c)*PIXEL_W +: PIXEL_W],
//                r=0 oldest row, c=0 oldest column
//   win_valid_o  window/coordinates valid (one-cycle pulse)
//   win_x_o      column of window centre
//   win_y_o      row of window centre
//   eof_o        with win_valid_o, last window of the frame
//   drop_o       pulse: pixel discarded while idle without sof_i
//   dbg_state    FSM state for observation (1 = ACTIVE)
module sobel_window #(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int X_W     = $clog2(IMG_W),
    parameter int Y_W     = $clog2(IMG_H)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PIXEL_W-1:0]   pix_i,
    input  logic                 pix_valid_i,
    input  logic                 sof_i,
    output logic [9*PIXEL_W-1:0] win_o,
    output logic                 win_valid_o,
    output logic [X_W-1:0]       win_x_o,
    output logic [Y_W-1:0]       win_y_o,
    output logic                 eof_o,
    output logic                 drop_o,
    output logic                 dbg_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [X_W-1:0] COL_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(IMG_H - 1);

    state_t             state;
    logic [X_W-1:0]     col;
    logic [Y_W-1:0]     row;

    // Line memories: lb1 holds row-1, lb0 holds row-2 (no reset needed;
    // rows 0/1 of every frame rewrite them before any window uses them).
    logic [PIXEL_W-1:0] lb0 [IMG_W];
    logic [PIXEL_W-1:0] lb1 [IMG_W];

    logic               accept;
    logic [X_W-1:0]     eff_col;
    logic [Y_W-1:0]     eff_row;
    logic [PIXEL_W-1:0] rd0;
    logic [PIXEL_W-1:0] rd1;
    logic               win_ok;
    logic               last_pix;

    // A sof pixel restarts the frame from any state, so it is always treated
    // as position (0,0) regardless of where the counters currently are.
    assign accept   = pix_valid_i && ((state == ACTIVE) || sof_i);
    assign eff_col  = sof_i ? '0 : col;
    assign eff_row  = sof_i ? '0 : row;
    assign rd0      = lb0[eff_col];
    assign rd1      = lb1[eff_col];
    assign win_ok   = (eff_row >= Y_W'(2)) && (eff_col >= X_W'(2));
    assign last_pix = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
    assign dbg_state = (state == ACTIVE);

    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb0[eff_col] <= rd1;
            lb1[eff_col] <= pix_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            win_o       <= '0;
            win_valid_o <= 1'b0;
            win_x_o     <= '0;
            win_y_o     <= '0;
            eof_o       <= 1'b0;
            drop_o      <= 1'b0;
        end else begin
            win_valid_o <= 1'b0;
            eof_o       <= 1'b0;
            drop_o      <= 1'b0;

            if (pix_valid_i && !accept) begin
                drop_o <= 1'b1;
            end

            if (accept) begin
                // Shift window left one column; new column enters at c=2.
                for (int r = 0; r < 3; r++) begin
                    win_o[(r*3+0)*PIXEL_W +: PIXEL_W] <= win_o[(r*3+1)*PIXEL_W +: PIXEL_W];
                    win_o[(r*3+1)*PIXEL_W +: PIXEL_W] <= win_o[(r*3+2)*PIXEL_W +: PIXEL_W];
                end
                win_o[(0*3+2)*PIXEL_W +: PIXEL_W] <= rd0;
                win_o[(1*3+2)*PIXEL_W +: PIXEL_W] <= rd1;
                win_o[(2*3+2)*PIXEL_W +: PIXEL_W] <= pix_i;

                // Requiring col>=2 guarantees all three columns belong to the
                // current line, so wrap-around columns never appear.
                if (win_ok) begin
                    win_valid_o <= 1'b1;
                    win_x_o     <= eff_col - X_W'(1);
                    win_y_o     <= eff_row - Y_W'(1);
                    eof_o       <= last_pix;
                end

                if (last_pix) begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end else if (eff_col == COL_LAST) begin
                    state <= ACTIVE;
                    col   <= '0;
                    row   <= eff_row + Y_W'(1);
                end else begin
                    state <= ACTIVE;
                    col   <= eff_col + X_W'(1);
                    row   <= eff_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// tb_sobel_window
//   Directed bench for sobel_window on a 4x4 image. Pixel value is
//   base + row*16 + col so every window element is predictable by hand.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, after the edge that accepted the pixel.
module tb_sobel_window;

    localparam int PIXEL_W = 8;
    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int X_W     = $clog2(IMG_W);
    localparam int Y_W     = $clog2(IMG_H);

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b1;
    logic [PIXEL_W-1:0]   pix_i = '0;
    logic                 pix_valid_i = 1'b0;
    logic                 sof_i = 1'b0;
    logic [9*PIXEL_W-1:0] win_o;
    logic                 win_valid_o;
    logic [X_W-1:0]       win_x_o;
    logic [Y_W-1:0]       win_y_o;
    logic                 eof_o;
    logic                 drop_o;
    logic                 dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    sobel_window #(
        .PIXEL_W(PIXEL_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .pix_i      (pix_i),
        .pix_valid_i(pix_valid_i),
        .sof_i      (sof_i),
        .win_o      (win_o),
        .win_valid_o(win_valid_o),
        .win_x_o    (win_x_o),
        .win_y_o    (win_y_o),
        .eof_o      (eof_o),
        .drop_o     (drop_o),
        .dbg_state  (dbg_state)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input logic [7:0] base, input int cr, input int cc);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'(int'(base) + (cr - 1 + r) * 16 + (cc - 1 + c));
        return w;
    endfunction

    // Present one input cycle; return sampled 1 unit after the edge.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        pix_valid_i = v;
        sof_i       = s;
        pix_i       = p;
        @(posedge clk_i);
        #1;
        pix_valid_i = 1'b0;
        sof_i       = 1'b0;
    endtask

    // Send the first n_pix pixels of a frame (sof on the first one).
    task automatic run_frame(input logic [7:0] base, input int n_pix, input bit gaps);
        int seen;
        logic [71:0] last_win;
        seen = 0;
        last_win = '0;
        for (int i = 0; i < n_pix; i++) begin
            int r;
            int c;
            r = i / IMG_W;
            c = i % IMG_W;
            step(1'b1, i == 0, 8'(int'(base) + r * 16 + c));
            if (win_valid_o) seen++;
            if (r >= 2 && c >= 2) begin
                chk("win_valid", 72'(win_valid_o), 72'd1);
                chk("win_x", 72'(win_x_o), 72'(c - 1));
                chk("win_y", 72'(win_y_o), 72'(r - 1));
                chk("win", win_o, exp_win(base, r - 1, c - 1));
                chk("eof", 72'(eof_o), 72'(r == IMG_H - 1 && c == IMG_W - 1));
                last_win = exp_win(base, r - 1, c - 1);
            end else begin
                chk("no_win", 72'(win_valid_o), 72'd0);
                chk("no_eof", 72'(eof_o), 72'd0);
            end
            if (gaps) begin
                step(1'b0, 1'b0, 8'hEE);
                chk("gap_valid", 72'(win_valid_o), 72'd0);
                step(1'b0, 1'b0, 8'hEE);
                chk("gap_valid2", 72'(win_valid_o), 72'd0);
                if (r >= 2 && c >= 2) chk("gap_hold", win_o, last_win);
            end
        end
        if (n_pix == IMG_W * IMG_H) begin
            chk("win_count", 72'(seen), 72'((IMG_W - 2) * (IMG_H - 2)));
            chk("idle_after", 72'(dbg_state), 72'd0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 72'(win_valid_o), 72'd0);
        chk("rst_win", win_o, 72'd0);
        chk("rst_eof", 72'(eof_o), 72'd0);
        chk("rst_drop", 72'(drop_o), 72'd0);
        chk("rst_state", 72'(dbg_state), 72'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Continuous frame
        run_frame(8'h00, 16, 1'b0);
        // Same frame with gaps between pixels
        run_frame(8'h00, 16, 1'b1);
        // Back-to-back frames
        run_frame(8'h00, 16, 1'b0);
        run_frame(8'h80, 16, 1'b0);

        // Pixels without sof while idle are dropped
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'(8'h30 + i));
            chk("drop_pulse", 72'(drop_o), 72'd1);
            chk("drop_nowin", 72'(win_valid_o), 72'd0);
            chk("drop_state", 72'(dbg_state), 72'd0);
        end
        step(1'b0, 1'b0, 8'h00);
        chk("drop_clear", 72'(drop_o), 72'd0);
        run_frame(8'h10, 16, 1'b0);

        // Early restart: abort at (2,1), new frame sof arrives there
        run_frame(8'hC0, 9, 1'b0);
        chk("abort_active", 72'(dbg_state), 72'd1);
        run_frame(8'h40, 16, 1'b0);

        // Asynchronous reset during row 2, right after a window pulse
        run_frame(8'h00, 11, 1'b0);
        chk("pre_rst_valid", 72'(win_valid_o), 72'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_valid", 72'(win_valid_o), 72'd0);
        chk("arst_eof", 72'(eof_o), 72'd0);
        chk("arst_drop", 72'(drop_o), 72'd0);
        chk("arst_win", win_o, 72'd0);
        chk("arst_state", 72'(dbg_state), 72'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 8'(8'h22 + i));
            chk("post_rst_drop", 72'(drop_o), 72'd1);
            chk("post_rst_nowin", 72'(win_valid_o), 72'd0);
        end
        run_frame(8'h20, 16, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
